// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: state encoding, ALU opcodes and
// default bus widths used by the controller, benches and command sources.
package alu_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int OPW_DEF   = 4;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_B = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h4;
  localparam logic [3:0] OP_NOT   = 4'h5;
  localparam logic [3:0] OP_SHL   = 4'h6;
  localparam logic [3:0] OP_SHR   = 4'h7;
  localparam logic [3:0] OP_INC   = 4'h8;
  localparam logic [3:0] OP_DEC   = 4'h9;
  localparam logic [3:0] OP_NAND  = 4'hA;
  localparam logic [3:0] OP_NOR   = 4'hB;
  localparam logic [3:0] OP_XNOR  = 4'hC;
  localparam logic [3:0] OP_PASSA = 4'hD;
  localparam logic [3:0] OP_PASSB = 4'hE;
  localparam logic [3:0] OP_ZERO  = 4'hF;

endpackage

// File: rtl/alu_phase_timer.sv
// Loadable down-counter; done is high during the last cycle of a phase.
module alu_phase_timer #(
  parameter int TW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          done
);

  logic [TW-1:0] count;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (count != '0)
      count <= count - TW'(1);
  end

  assign done = (count == '0);

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequences one command into the ALU's switches/mode load interface and
// returns the settled result over a valid/ready response channel.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH         = WIDTH_DEF,
  parameter int OPW           = OPW_DEF,
  parameter int LOAD_CYCLES   = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [OPW-1:0]   cmd_opcode,
  input  logic             cmd_reuse_a,
  output logic [WIDTH-1:0] alu_switches,
  output logic             alu_mode,
  output logic [OPW-1:0]   alu_opcode,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cout,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_cout,
  output logic             rsp_zero,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam int PH_MAX = (LOAD_CYCLES > SETTLE_CYCLES) ? LOAD_CYCLES : SETTLE_CYCLES;
  localparam int TW     = $clog2(PH_MAX) + 1;
  localparam logic [TW-1:0] LOAD_VAL   = TW'(LOAD_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_VAL = TW'(SETTLE_CYCLES - 1);

  logic [2:0]       state, state_next;
  logic             a_loaded;
  logic [WIDTH-1:0] hold_b;
  logic             t_load, t_done;
  logic [TW-1:0]    t_val;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  // The timer is reloaded on every entry into a timed state.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    t_load     = 1'b0;
    t_val      = LOAD_VAL;
    case (state)
      S_IDLE: if (cmd_valid && cmd_ready) begin
        t_load     = 1'b1;
        state_next = (cmd_reuse_a && a_loaded) ? S_LOAD_B : S_LOAD_A;
      end
      S_LOAD_A: if (t_done) begin
        t_load     = 1'b1;
        state_next = S_LOAD_B;
      end
      S_LOAD_B: if (t_done) begin
        t_load     = 1'b1;
        t_val      = SETTLE_VAL;
        state_next = S_EXEC;
      end
      S_EXEC:  if (t_done) state_next = S_DONE;
      S_DONE:  if (rsp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  alu_phase_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (t_load),
    .load_val (t_val),
    .done     (t_done)
  );

  // ALU-facing outputs are set on phase entry and otherwise hold their value.
  // NOTE: all state here is control/datapath flops, not memory, so all are reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      a_loaded     <= 1'b0;
      hold_b       <= '0;
      alu_switches <= '0;
      alu_mode     <= 1'b0;
      alu_opcode   <= '0;
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_cout     <= 1'b0;
      rsp_zero     <= 1'b0;
      op_count     <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: if (cmd_valid && cmd_ready) begin
          hold_b     <= cmd_b;
          alu_opcode <= cmd_opcode;
          if (state_next == S_LOAD_A) begin
            alu_mode     <= 1'b0;
            alu_switches <= cmd_a;
          end else begin
            alu_mode     <= 1'b1;
            alu_switches <= cmd_b;
          end
        end
        S_LOAD_A: if (t_done) begin
          a_loaded     <= 1'b1;
          alu_mode     <= 1'b1;
          alu_switches <= hold_b;
        end
        S_EXEC: if (t_done) begin
          rsp_result <= alu_out;
          rsp_cout   <= alu_cout;
          rsp_zero   <= alu_zero;
          rsp_valid  <= 1'b1;
        end
        S_DONE: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          op_count  <= op_count + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural ALU on the load interface.
module tb_alu_seq_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_reuse_a = 1'b0, rsp_ready = 1'b0;
  logic        cmd_ready, alu_mode, alu_cout, alu_zero, rsp_valid, rsp_cout, rsp_zero, busy;
  logic [15:0] cmd_a = '0, cmd_b = '0, alu_switches, alu_out, rsp_result, op_count;
  logic [3:0]  cmd_opcode = '0, alu_opcode;
  logic [15:0] ra, rb;
  int          checks = 0, errors = 0;

  alu_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_opcode(cmd_opcode), .cmd_reuse_a(cmd_reuse_a),
    .alu_switches(alu_switches), .alu_mode(alu_mode), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_cout(alu_cout), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_cout(rsp_cout), .rsp_zero(rsp_zero), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Board ALU: latches switches into A (mode=0) or B (mode=1) every clock.
  function automatic logic [16:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      OP_ADD:   return {1'b0, a} + {1'b0, b};
      OP_SUB:   return {1'b0, a} - {1'b0, b};
      OP_AND:   return {1'b0, a & b};
      OP_OR:    return {1'b0, a | b};
      OP_XOR:   return {1'b0, a ^ b};
      OP_NOT:   return {1'b0, ~a};
      OP_SHL:   return {a[15], a[14:0], 1'b0};
      OP_SHR:   return {a[0], 1'b0, a[15:1]};
      OP_INC:   return {1'b0, a} + 17'd1;
      OP_DEC:   return {1'b0, a} - 17'd1;
      OP_NAND:  return {1'b0, ~(a & b)};
      OP_NOR:   return {1'b0, ~(a | b)};
      OP_XNOR:  return {1'b0, ~(a ^ b)};
      OP_PASSA: return {1'b0, a};
      OP_PASSB: return {1'b0, b};
      default:  return 17'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (alu_mode) rb <= alu_switches;
    else          ra <= alu_switches;
  end
  assign {alu_cout, alu_out} = alu_fn(alu_opcode, ra, rb);
  assign alu_zero = (alu_out == 16'h0000);

  // Hand-computed results for A=0x0005, B=0x0003 across opcodes 0..15.
  logic [15:0] exp_res [16] = '{16'h0008, 16'h0002, 16'h0001, 16'h0007, 16'h0006, 16'hFFFA,
                                16'h000A, 16'h0002, 16'h0006, 16'h0004, 16'hFFFE, 16'hFFF8,
                                16'hFFF9, 16'h0005, 16'h0003, 16'h0000};
  logic [15:0] exp_cout_bits = 16'h0080;

  // Latency counts clock edges starting with the accept edge as 1.
  task automatic run_cmd(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                         input logic reuse, output int lat, output int m0, output int m1);
    @(negedge clk);
    cmd_a = a; cmd_b = b; cmd_opcode = op; cmd_reuse_a = reuse; cmd_valid = 1'b1;
    @(posedge clk);
    lat = 1; m0 = 0; m1 = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0; cmd_reuse_a = 1'b0;
      if (rsp_valid) break;
      if (alu_mode) m1++; else m0++;
      @(posedge clk);
      lat++;
    end
    if (!rsp_valid) lat = -1;
  endtask

  task automatic ack_rsp;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if ({cmd_ready, busy, rsp_valid} !== 3'b100) begin errors++;
      $display("FAIL reset_flags got ready/busy/valid=%b want 100", {cmd_ready, busy, rsp_valid}); end
    checks++; if (op_count !== 16'h0000) begin errors++;
      $display("FAIL reset_op_count got %h want 0000", op_count); end
    checks++; if ({alu_switches, alu_mode, alu_opcode, rsp_result} !== 37'd0) begin errors++;
      $display("FAIL reset_outputs got sw=%h mode=%b op=%h res=%h want zeros", alu_switches, alu_mode, alu_opcode, rsp_result); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_add;
    int lat, m0, m1;
    run_cmd(16'h0005, 16'h0003, OP_ADD, 1'b0, lat, m0, m1);
    checks++; if (lat !== 7) begin errors++; $display("FAIL add_latency got %0d want 7", lat); end
    checks++; if (m0 !== 2 || m1 !== 4) begin errors++;
      $display("FAIL add_mode_phases got m0=%0d m1=%0d want 2/4", m0, m1); end
    checks++; if ({rsp_result, rsp_cout, rsp_zero} !== {16'h0008, 2'b00}) begin errors++;
      $display("FAIL add_result got %h c=%b z=%b want 0008 c=0 z=0", rsp_result, rsp_cout, rsp_zero); end
    ack_rsp();
    checks++; if (op_count !== 16'd1 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++;
      $display("FAIL add_ack got cnt=%0d valid=%b ready=%b want 1/0/1", op_count, rsp_valid, cmd_ready); end
    checks++; if ({alu_switches, alu_mode, alu_opcode} !== {16'h0003, 1'b1, OP_ADD}) begin errors++;
      $display("FAIL add_retain got sw=%h mode=%b op=%h want 0003/1/0", alu_switches, alu_mode, alu_opcode); end
  endtask

  task automatic test_operand_reuse;
    int lat, m0, m1;
    // A argument is junk: a reused A must come from the ALU, not the bus.
    run_cmd(16'hDEAD, 16'h0005, OP_SUB, 1'b1, lat, m0, m1);
    checks++; if (lat !== 5) begin errors++; $display("FAIL reuse_latency got %0d want 5", lat); end
    checks++; if (m0 !== 0) begin errors++; $display("FAIL reuse_no_load_a got m0=%0d want 0", m0); end
    checks++; if ({rsp_result, rsp_zero} !== {16'h0000, 1'b1}) begin errors++;
      $display("FAIL reuse_result got %h z=%b want 0000 z=1", rsp_result, rsp_zero); end
    ack_rsp();
  endtask

  task automatic test_carry;
    int lat, m0, m1;
    run_cmd(16'hFFFF, 16'h0001, OP_ADD, 1'b0, lat, m0, m1);
    checks++; if ({rsp_result, rsp_cout, rsp_zero} !== {16'h0000, 2'b11}) begin errors++;
      $display("FAIL carry_result got %h c=%b z=%b want 0000 c=1 z=1", rsp_result, rsp_cout, rsp_zero); end
    ack_rsp();
    checks++; if (op_count !== 16'd3) begin errors++; $display("FAIL carry_count got %0d want 3", op_count); end
  endtask

  task automatic test_backpressure;
    int lat, m0, m1;
    run_cmd(16'h1234, 16'h0101, OP_XOR, 1'b0, lat, m0, m1);
    cmd_a = 16'hFFFF; cmd_b = 16'hFFFF; cmd_opcode = OP_ZERO; cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if ({rsp_valid, cmd_ready, rsp_result} !== {2'b10, 16'h1335}) begin errors++;
        $display("FAIL backpressure_hold cyc=%0d got v=%b r=%b res=%h want 1/0/1335", i, rsp_valid, cmd_ready, rsp_result); end
    end
    cmd_valid = 1'b0;
    ack_rsp();
    checks++; if (op_count !== 16'd4) begin errors++; $display("FAIL backpressure_count got %0d want 4", op_count); end
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rsp_ready = 1'b0;
    checks++; if (op_count !== 16'd4 || busy !== 1'b0) begin errors++;
      $display("FAIL idle_ready_ignored got cnt=%0d busy=%b want 4/0", op_count, busy); end
  endtask

  task automatic test_reset_mid_op;
    int lat, m0, m1;
    @(negedge clk);
    cmd_a = 16'h0007; cmd_b = 16'h0002; cmd_opcode = OP_SUB; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (busy !== 1'b1 || alu_mode !== 1'b1) begin errors++;
      $display("FAIL pre_reset_load_b got busy=%b mode=%b want 1/1", busy, alu_mode); end
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, cmd_ready, rsp_valid} !== 3'b010 || op_count !== 16'd0) begin errors++;
      $display("FAIL async_reset got busy/ready/valid=%b cnt=%0d want 010/0", {busy, cmd_ready, rsp_valid}, op_count); end
    @(negedge clk);
    rst_n = 1'b1;
    run_cmd(16'h0007, 16'h0002, OP_SUB, 1'b1, lat, m0, m1);
    checks++; if (lat !== 7 || m0 !== 2) begin errors++;
      $display("FAIL post_reset_full_load got lat=%0d m0=%0d want 7/2", lat, m0); end
    checks++; if (rsp_result !== 16'h0005) begin errors++;
      $display("FAIL post_reset_result got %h want 0005", rsp_result); end
    ack_rsp();
  endtask

  task automatic test_opcode_sweep;
    int lat, m0, m1;
    do_reset();
    for (int op = 0; op < 16; op++) begin
      run_cmd(16'h0005, 16'h0003, 4'(op), 1'b0, lat, m0, m1);
      checks++;
      if (rsp_result !== exp_res[op] || rsp_cout !== exp_cout_bits[op] || rsp_zero !== (exp_res[op] == 16'h0)) begin
        errors++;
        $display("FAIL sweep_op%0d got %h c=%b z=%b want %h c=%b", op, rsp_result, rsp_cout, rsp_zero, exp_res[op], exp_cout_bits[op]);
      end
      ack_rsp();
    end
    checks++; if (op_count !== 16'd16) begin errors++; $display("FAIL sweep_count got %0d want 16", op_count); end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_operand_reuse();
    test_carry();
    test_backpressure();
    test_reset_mid_op();
    test_opcode_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
